vu_meter_peak_nch: RTL and testbench

Parametrised multi-channel VU meter with attack/decay level tracking, per-channel peak-hold LED, and sticky clip detection. It consumes time-multiplexed signed PCM samples over a ready/valid stream, such as the channel-tagged output of the I2S capture or RAM readout path. Per channel it drives a thermometer bar plus a peak dot. It succeeds the single-channel, fixed-6-LED meter and runs in the 27 MHz system clock domain.

---
 rtl/vu_meter_peak_nch.sv | 181 ++++++++++++++++++
 tb/tb_vu_meter_peak_nch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vu_meter_peak_nch.sv
// vu_meter_peak_nch: multi-channel VU meter with attack/decay level
// tracking, per-channel peak-hold dot and sticky clip flags.
module vu_meter_peak_nch #(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_W     = 24,
    parameter int NUM_LEDS     = 6,
    parameter int LEVEL_W      = 32,
    parameter int SCALE_SHIFT  = 12,
    parameter int ATTACK_SHIFT = 3,
    parameter int DECAY_SHIFT  = 11,
    parameter int TH_BASE      = 1000,
    parameter int HOLD_TICKS   = 25,
    parameter int LED_DIV      = 540000,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic signed [SAMPLE_W-1:0] s_data_i,
    input  logic [CH_W-1:0]            s_ch_i,
    input  logic                       clip_clr_i,
    output logic [NUM_CH*NUM_LEDS-1:0] leds_o,
    output logic [NUM_CH-1:0]          clip_o
);

    localparam int BW = $clog2(NUM_LEDS + 1);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int DW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam int TW = LEVEL_W + 48;

    localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {ST_ACCEPT, ST_UPDATE} state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic [LEVEL_W-1:0]        m_q;
    logic [CH_W-1:0]           ch_q;
    logic                      chv_q;
    logic [NUM_CH-1:0]         clip_q;
    logic [LEVEL_W-1:0]        level_q [NUM_CH];
    logic [BW-1:0]             pk_q    [NUM_CH];
    logic [HW-1:0]             hold_q  [NUM_CH];
    logic [NUM_CH*NUM_LEDS-1:0] leds_q;
    logic [DW-1:0]             div_q;

    logic [SAMPLE_W-2:0]       s_mag;
    logic [LEVEL_W-1:0]        m_d;
    logic                      s_hit;
    logic                      ch_ok;
    logic                      acc;
    logic [NUM_CH-1:0]         clip_set;
    logic [CH_W-1:0]           ch_idx;
    logic [LEVEL_W-1:0]        lvl;
    logic [LEVEL_W-1:0]        up;
    logic [LEVEL_W-1:0]        dn;
    logic [LEVEL_W-1:0]        level_d;
    logic                      tick;
    logic [BW-1:0]             bar;
    logic [TW-1:0]             th;
    logic [BW-1:0]             pk_d    [NUM_CH];
    logic [HW-1:0]             hold_d  [NUM_CH];
    logic [NUM_CH*NUM_LEDS-1:0] leds_d;

    assign acc   = s_valid_i & ready_q;
    assign ch_ok = (32'(s_ch_i) < NUM_CH);
    assign s_hit = (s_data_i == S_MAX) || (s_data_i == S_MIN);

    // Most negative code saturates to the largest positive magnitude
    always_comb begin
        s_mag = s_data_i[SAMPLE_W-2:0];
        if (s_data_i == S_MIN)
            s_mag = S_MAX[SAMPLE_W-2:0];
        else if (s_data_i[SAMPLE_W-1])
            s_mag = (SAMPLE_W-1)'(-s_data_i);
        m_d = LEVEL_W'(s_mag) >> SCALE_SHIFT;
    end

    always_comb begin
        clip_set = '0;
        for (int c = 0; c < NUM_CH; c++)
            clip_set[c] = acc && ch_ok && s_hit && (32'(s_ch_i) == c);
    end

    always_comb begin
        ch_idx  = chv_q ? ch_q : '0;
        lvl     = level_q[ch_idx];
        up      = (m_q - lvl) >> ATTACK_SHIFT;
        dn      = lvl >> DECAY_SHIFT;
        if (up == '0) up = LEVEL_W'(1);
        if (dn == '0) dn = LEVEL_W'(1);
        level_d = lvl;
        if (m_q > lvl)
            level_d = lvl + up;
        else if (lvl != '0)
            level_d = lvl - dn;
    end

    // Display path reads the stored level, so a coincident write is seen next tick
    always_comb begin
        tick   = (div_q == DW'(LED_DIV - 1));
        leds_d = '0;
        bar    = '0;
        th     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pk_d[c]   = pk_q[c];
            hold_d[c] = hold_q[c];
            bar       = '0;
            for (int k = 0; k < NUM_LEDS; k++) begin
                th = TW'(TH_BASE) << k;
                if (th[TW-1:LEVEL_W] == '0 && level_q[c] > th[LEVEL_W-1:0])
                    bar = bar + BW'(1);
            end
            if (bar >= pk_q[c]) begin
                pk_d[c]   = bar;
                hold_d[c] = HW'(HOLD_TICKS);
            end else if (hold_q[c] != '0) begin
                hold_d[c] = hold_q[c] - HW'(1);
            end else begin
                pk_d[c] = pk_q[c] - BW'(1);
            end
            for (int k = 0; k < NUM_LEDS; k++)
                leds_d[c*NUM_LEDS + k] = (BW'(k) < bar) ||
                    (pk_d[c] != '0 && BW'(k) == pk_d[c] - BW'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ACCEPT;
            ready_q <= 1'b0;
            m_q     <= '0;
            ch_q    <= '0;
            chv_q   <= 1'b0;
            clip_q  <= '0;
            leds_q  <= '0;
            div_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                level_q[c] <= '0;
                pk_q[c]    <= '0;
                hold_q[c]  <= '0;
            end
        end else begin
            clip_q <= (clip_q & ~{NUM_CH{clip_clr_i}}) | clip_set;
            div_q  <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                leds_q <= leds_d;
                for (int c = 0; c < NUM_CH; c++) begin
                    pk_q[c]   <= pk_d[c];
                    hold_q[c] <= hold_d[c];
                end
            end
            unique case (state_q)
                ST_ACCEPT: begin
                    if (acc) begin
                        m_q     <= m_d;
                        ch_q    <= s_ch_i;
                        chv_q   <= ch_ok;
                        state_q <= ST_UPDATE;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (chv_q)
                        level_q[ch_idx] <= level_d;
                    state_q <= ST_ACCEPT;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready_o = ready_q;
    assign leds_o    = leds_q;
    assign clip_o    = clip_q;

endmodule

// File: tb/tb_vu_meter_peak_nch.sv
// tb_vu_meter_peak_nch: directed vector bench for vu_meter_peak_nch
// with small display parameters so ticks come every 16 clocks.
module tb_vu_meter_peak_nch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic               s_valid_i;
    logic               s_ready_o;
    logic signed [23:0] s_data_i;
    logic [0:0]         s_ch_i;
    logic               clip_clr_i;
    logic [7:0]         leds_o;
    logic [1:0]         clip_o;

    logic               v3;
    logic               r3;
    logic signed [23:0] d3;
    logic [1:0]         ch3;
    logic [11:0]        leds3;
    logic [2:0]         clip3;

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= rst_i ? 0 : cyc + 1;

    vu_meter_peak_nch #(
        .NUM_CH(2), .SAMPLE_W(24), .NUM_LEDS(4), .LEVEL_W(32),
        .SCALE_SHIFT(0), .ATTACK_SHIFT(0), .DECAY_SHIFT(2),
        .TH_BASE(16), .HOLD_TICKS(2), .LED_DIV(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_data_i(s_data_i), .s_ch_i(s_ch_i),
        .clip_clr_i(clip_clr_i), .leds_o(leds_o), .clip_o(clip_o)
    );

    vu_meter_peak_nch #(
        .NUM_CH(3), .SAMPLE_W(24), .NUM_LEDS(4), .LEVEL_W(32),
        .SCALE_SHIFT(0), .ATTACK_SHIFT(0), .DECAY_SHIFT(2),
        .TH_BASE(16), .HOLD_TICKS(2), .LED_DIV(16)
    ) dut3 (
        .clk_i(clk), .rst_i(rst_i),
        .s_valid_i(v3), .s_ready_o(r3),
        .s_data_i(d3), .s_ch_i(ch3),
        .clip_clr_i(clip_clr_i), .leds_o(leds3), .clip_o(clip3)
    );

    typedef struct {
        logic               ch;
        logic signed [23:0] d;
        logic [31:0]        lvl;
        logic [1:0]         clip;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        s_valid_i  = 1'b0;
        clip_clr_i = 1'b0;
        v3         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", 32'(s_ready_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(s_ready_o), 32'd1);
    endtask

    task automatic send(input logic ch, input logic signed [23:0] d,
                        input logic clr);
        int n = 0;
        s_valid_i = 1'b1;
        s_ch_i    = ch;
        s_data_i  = d;
        while (!s_ready_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            nvec++;
            nbad++;
            $display("FAIL send_timeout: got ready 0 want 1");
        end
        clip_clr_i = clr;
        @(posedge clk);
        #1;
        s_valid_i  = 1'b0;
        clip_clr_i = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic signed [23:0] d);
        int n = 0;
        v3  = 1'b1;
        ch3 = ch;
        d3  = d;
        while (!r3 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            nvec++;
            nbad++;
            $display("FAIL send3_timeout: got ready 0 want 1");
        end
        @(posedge clk);
        #1;
        v3 = 1'b0;
    endtask

    task automatic to_tick();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 16 != 0);
    endtask

    initial begin
        int nacc;
        vec[0]  = '{1'b0,  24'sd100,     32'd100,     2'b00};
        vec[1]  = '{1'b0,  24'sd0,       32'd75,      2'b00};
        vec[2]  = '{1'b0,  24'sd0,       32'd57,      2'b00};
        vec[3]  = '{1'b0,  24'sd0,       32'd43,      2'b00};
        vec[4]  = '{1'b0,  24'sd0,       32'd33,      2'b00};
        vec[5]  = '{1'b0,  24'sd0,       32'd25,      2'b00};
        vec[6]  = '{1'b0, -24'sd40,      32'd40,      2'b00};
        vec[7]  = '{1'b0,  24'sd40,      32'd30,      2'b00};
        vec[8]  = '{1'b1, -24'sd1,       32'd1,       2'b00};
        vec[9]  = '{1'b1,  24'sd0,       32'd0,       2'b00};
        vec[10] = '{1'b1,  24'sd0,       32'd0,       2'b00};
        vec[11] = '{1'b1, -24'sd8388608, 32'd8388607, 2'b10};
        vec[12] = '{1'b0,  24'sd8388607, 32'd8388607, 2'b11};
        vec[13] = '{1'b0, -24'sd8388607, 32'd6291456, 2'b11};

        s_data_i = '0;
        s_ch_i   = '0;
        d3       = '0;
        ch3      = '0;

        do_reset();
        repeat (40) @(posedge clk);
        #1;
        chk("idle_leds", 32'(leds_o), 32'd0);
        chk("idle_clip", 32'(clip_o), 32'd0);

        foreach (vec[i]) begin
            send(vec[i].ch, vec[i].d, 1'b0);
            chk($sformatf("vec%0d_clip", i), 32'(clip_o), 32'(vec[i].clip));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_level", i), dut.level_q[vec[i].ch],
                vec[i].lvl);
        end

        do_reset();
        chk("rst_leds", 32'(leds_o), 32'd0);
        chk("rst_clip", 32'(clip_o), 32'd0);
        send(1'b0, 24'sd100, 1'b0);
        to_tick();
        chk("bar3_ch0", 32'(leds_o[3:0]), 32'b0111);
        chk("bar3_ch1", 32'(leds_o[7:4]), 32'b0000);
        repeat (5) send(1'b0, 24'sd0, 1'b0);
        to_tick();
        chk("hold1_ch0", 32'(leds_o[3:0]), 32'b0101);
        to_tick();
        chk("hold2_ch0", 32'(leds_o[3:0]), 32'b0101);
        to_tick();
        chk("fall1_ch0", 32'(leds_o[3:0]), 32'b0011);
        to_tick();
        chk("fall2_ch0", 32'(leds_o[3:0]), 32'b0001);

        send(1'b1, -24'sd8388608, 1'b0);
        chk("clip_ch1", 32'(clip_o), 32'b10);
        @(posedge clk);
        #1;
        chk("neg_full_mag", dut.level_q[1], 32'd8388607);
        send(1'b0, 24'sd8388607, 1'b0);
        chk("clip_both", 32'(clip_o), 32'b11);
        send(1'b1, -24'sd8388608, 1'b1);
        chk("clip_set_wins", 32'(clip_o), 32'b10);
        clip_clr_i = 1'b1;
        @(posedge clk);
        #1;
        clip_clr_i = 1'b0;
        chk("clip_cleared", 32'(clip_o), 32'b00);

        send(1'b0, 24'sd500, 1'b0);
        do_reset();
        chk("abandoned_update", dut.level_q[0], 32'd0);

        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            s_valid_i = 1'b1;
            s_ch_i    = 1'b1;
            s_data_i  = 24'(200 + 10 * i);
            if (s_ready_o)
                nacc++;
            @(posedge clk);
            #1;
        end
        s_valid_i = 1'b0;
        chk("accept_count", 32'(nacc), 32'd5);
        chk("alt_level_ch1", dut.level_q[1], 32'd280);
        chk("alt_level_ch0", dut.level_q[0], 32'd0);

        send3(2'd3, 24'sd8388607);
        @(posedge clk);
        #1;
        chk("badch_clip", 32'(clip3), 32'd0);
        chk("badch_level", dut3.level_q[0] | dut3.level_q[1] | dut3.level_q[2],
            32'd0);
        send3(2'd2, 24'sd8388607);
        chk("ch2_clip", 32'(clip3), 32'b100);
        @(posedge clk);
        #1;
        chk("ch2_level", dut3.level_q[2], 32'd8388607);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
